// File: rtl/fetch_queue.sv
// fetch_queue: in-order {instruction, next_pc} buffer between fetch and decode.
// in_ready backpressures fetch (PCWrite). A flush discards everything, which
// keeps wrong-path instructions away from decode. All outputs depend only on
// registered state, with no input-to-output path.
module fetch_queue #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_instr,
    input  logic [15:0]      in_pc,
    output logic             in_ready,
    output logic             out_valid,
    output logic [15:0]      out_instr,
    output logic [15:0]      out_pc,
    input  logic             out_ready,
    input  logic             flush,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] CNT_FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [15:0]    NOP_INSTR = 16'h0800;

    logic [31:0]      entry [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic [PTR_W:0]   cnt;
    logic             push;
    logic             pop;

    // Handshakes and head presentation from registered state; empty shows a NOP
    always_comb begin
        in_ready  = rst & (cnt != CNT_FULL);
        out_valid = (cnt != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        out_instr = NOP_INSTR;
        out_pc    = '0;
        if (out_valid) begin
            out_instr = entry[rp][31:16];
            out_pc    = entry[rp][15:0];
        end
        count     = cnt;
    end

    // Pointer and occupancy update; flush overrides any push or pop that cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage has no reset; empty slots are masked at the output instead
    always_ff @(posedge clk) begin
        if (push && !flush) entry[wp] <= {in_instr, in_pc};
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small in-order instruction buffer between the instruction fetch stage and decode.
- Each entry holds an {instruction, next_pc} pair produced by fetch.
- Decouples decode stalls from fetch: in_ready drives fetch's PCWrite.
- Flushed on a taken branch or jump so wrong-path instructions never reach decode.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), read/write pointer width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  fetch presents a valid instruction this cycle.
- in_instr  input  16  instruction word from instruction memory.
- in_pc  input  16  next_pc (PC+2) associated with in_instr.
- in_ready  output  1  queue can accept a push; wired to fetch PCWrite.
- out_valid  output  1  head entry valid for decode.
- out_instr  output  16  head instruction; NOP 16'h0800 when empty.
- out_pc  output  16  head next_pc; 16'h0000 when empty.
- out_ready  input  1  decode consumes the head this cycle (decode not stalled).
- flush  input  1  taken branch/jump resolved (toJump | toBranch); discard all entries.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 32-bit register array (instr, pc), write pointer wp, read pointer rp, and occupancy cnt. Pointers wrap modulo DEPTH naturally.
- Reset (rst=0, asynchronous):
  - wp=rp=0, cnt=0.
  - out_valid=0, out_instr=16'h0800, out_pc=0, count=0.
  - in_ready=0 while rst is low.
  - Array contents are don't-care.
- Handshake signals (combinational from registered state only; no input-to-output combinational path):
  - in_ready = rst & (cnt != DEPTH).
  - out_valid = (cnt != 0).
- push = in_valid & in_ready. On the clock edge, entry[wp] <= {in_instr, in_pc} and wp <= wp+1.
- pop = out_valid & out_ready. On the clock edge, rp <= rp+1.
- cnt update: cnt+1 on push only, cnt-1 on pop only, unchanged on both or neither.
- Full: in_ready=0 even if decode pops that cycle, so there is no simultaneous push-on-full. The slot frees the following cycle.
- Empty: a push while empty becomes visible on the outputs the cycle after the push edge (1-cycle latency). There is no bypass.
- Outputs are driven directly from entry[rp]. When cnt==0 they are forced to NOP / 0, independent of stale array data.
- flush=1 at an edge:
  - wp<=0, rp<=0, cnt<=0.
  - A push or pop in the same cycle is ignored; flush has priority.
  - The next cycle shows out_valid=0 and in_ready=1.
- in_valid while in_ready=0: no state change; fetch must hold its values.
- out_ready while empty: no state change; rp is not advanced.
- Reset mid-operation discards all entries immediately (asynchronous); nothing is replayed.
- Ordering is strict FIFO. The instr/pc pair is never split across entries.

Test Plan:
- Reset, then push A=16'h1111/pc 0002 with out_ready=0 -> next cycle out_valid=1, out_instr=16'h1111, out_pc=16'h0002, count=1.
- Push 4 entries (16'h0001..0004) with out_ready=0 -> count=4, in_ready=0. A 5th push of 16'h0005 is held by fetch and not stored. After one pop, in_ready=1 the next cycle and 0005 is accepted as the tail.
- Continuous push+pop for 10 cycles from count=2 -> count stays 2. Outputs appear in push order, confirming wp/rp wrap past DEPTH.
- count=3 with flush=1 asserted together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_instr=16'h0800. The pushed word never appears on the outputs.
- Empty queue with out_ready=1 for 3 cycles -> count stays 0, outputs stay NOP/0. A subsequent push is output as the first entry.
- Drop rst asynchronously mid-cycle at count=3 -> outputs go to reset values before the next edge. After rst returns high, in_ready=1 and count=0.
